// File: rtl/ring_arbiter_if.sv
// Requester/arbiter bundle for ring_arbiter: level requests in, one-hot grant and ring status out.
interface ring_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         busy;
  logic [N-1:0] token;
  logic [7:0]   hold_cnt;
  logic         preempt;

  modport master (output req, input grant, busy, token, hold_cnt, preempt);
  modport slave  (input req, output grant, busy, token, hold_cnt, preempt);
endinterface

// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating token and a registered one-hot grant.
// Defining ARB_TIMEOUT_EN revokes a grant after MAX_HOLD cycles and pulses preempt.
module ring_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input logic           clk,
  input logic           reset,
  ring_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [N-1:0] ONE        = N'(1);
  localparam logic [7:0]   MAX_HOLD_C = 8'(MAX_HOLD);
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t       state, state_nx;
  logic [N-1:0] grant_q, grant_nx;
  logic [N-1:0] token_q, token_nx;
  logic [7:0]   hold_q, hold_nx;
  logic [N-1:0] req_hi, sel;
  logic         owner_req, timeout_hit;

  function automatic logic [N-1:0] lowest_set(input logic [N-1:0] x);
    return x & (~x + ONE);
  endfunction

  // Requests at or above the token win first; otherwise the scan wraps to bit 0.
  assign req_hi      = bus.req & ~(token_q - ONE);
  assign sel         = (|req_hi) ? lowest_set(req_hi) : lowest_set(bus.req);
  assign owner_req   = |(bus.req & grant_q);
  assign timeout_hit = TIMEOUT_EN && (hold_q == MAX_HOLD_C);

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned and infers a latch.
    state_nx = state;
    grant_nx = grant_q;
    token_nx = token_q;
    hold_nx  = hold_q;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          grant_nx = sel;
          hold_nx  = 8'd1;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req || timeout_hit) begin
          grant_nx = '0;
          hold_nx  = '0;
          token_nx = {grant_q[N-2:0], grant_q[N-1]};
          state_nx = IDLE;
        end else if (hold_q != 8'hFF) begin
          hold_nx = hold_q + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state   <= IDLE;
      grant_q <= '0;
      token_q <= ONE;
      hold_q  <= '0;
    end else begin
      state   <= state_nx;
      grant_q <= grant_nx;
      token_q <= token_nx;
      hold_q  <= hold_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic preempt_q;

  // A dropped request takes priority, so preempt fires only on a genuine timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) preempt_q <= 1'b0;
    else        preempt_q <= (state == GRANT) && owner_req && timeout_hit;
  end

  assign bus.preempt = preempt_q;
`else
  assign bus.preempt = 1'b0;
`endif

  assign bus.grant    = grant_q;
  assign bus.busy     = |grant_q;
  assign bus.token    = token_q;
  assign bus.hold_cnt = hold_q;
endmodule

// File: tb/tb_ring_arbiter.sv
// Directed bench for ring_arbiter (N=4, MAX_HOLD=8); covers both ARB_TIMEOUT_EN builds.
module tb_ring_arbiter;
  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] token;
    logic [7:0] hold;
    logic       preempt;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];

  ring_arbiter_if #(.N(4)) bus ();

  ring_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] g, input logic [3:0] t,
                              input logic [7:0] h, input logic p);
    exp_t e;
    e.grant = g; e.token = t; e.hold = h; e.preempt = p;
    return e;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".grant"},   {4'b0, bus.grant},  {4'b0, e.grant});
    check({tag, ".token"},   {4'b0, bus.token},  {4'b0, e.token});
    check({tag, ".busy"},    {7'b0, bus.busy},   {7'b0, |e.grant});
    check({tag, ".hold"},    bus.hold_cnt,       e.hold);
    check({tag, ".preempt"}, {7'b0, bus.preempt}, {7'b0, e.preempt});
  endtask

  task automatic step(input string tag, input logic [3:0] r, input exp_t e);
    bus.req = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req = 4'b0000;

    // Reset held low across clock edges
    sb.push_back(mk(4'b0000, 4'b0001, 8'd0, 1'b0));
    @(posedge clk); #1;
    compare("reset");
    @(negedge clk) reset = 1'b1;

    for (int k = 0; k < 10; k++) step("idle", 4'b0000, mk(4'b0000, 4'b0001, 8'd0, 1'b0));

    // Single requester, three sampled cycles of request
    step("single1", 4'b0100, mk(4'b0100, 4'b0001, 8'd1, 1'b0));
    step("single2", 4'b0100, mk(4'b0100, 4'b0001, 8'd2, 1'b0));
    step("single3", 4'b0100, mk(4'b0100, 4'b0001, 8'd3, 1'b0));
    step("single_rel", 4'b0000, mk(4'b0000, 4'b1000, 8'd0, 1'b0));
    step("single_idle", 4'b0000, mk(4'b0000, 4'b1000, 8'd0, 1'b0));

    // Return the token to bit 0 before the fairness sequence
    reset = 1'b0;
    #1;
    sb.push_back(mk(4'b0000, 4'b0001, 8'd0, 1'b0));
    compare("rst2");
    @(negedge clk) reset = 1'b1;

    step("rr0a", 4'b1111, mk(4'b0001, 4'b0001, 8'd1, 1'b0));
    step("rr0b", 4'b1111, mk(4'b0001, 4'b0001, 8'd2, 1'b0));
    step("rr0r", 4'b1110, mk(4'b0000, 4'b0010, 8'd0, 1'b0));
    step("rr1a", 4'b1111, mk(4'b0010, 4'b0010, 8'd1, 1'b0));
    step("rr1b", 4'b1111, mk(4'b0010, 4'b0010, 8'd2, 1'b0));
    step("rr1r", 4'b1101, mk(4'b0000, 4'b0100, 8'd0, 1'b0));
    step("rr2a", 4'b1111, mk(4'b0100, 4'b0100, 8'd1, 1'b0));
    step("rr2b", 4'b1111, mk(4'b0100, 4'b0100, 8'd2, 1'b0));
    step("rr2r", 4'b1011, mk(4'b0000, 4'b1000, 8'd0, 1'b0));
    step("rr3a", 4'b1111, mk(4'b1000, 4'b1000, 8'd1, 1'b0));
    step("rr3b", 4'b1111, mk(4'b1000, 4'b1000, 8'd2, 1'b0));
    step("rr3r", 4'b0111, mk(4'b0000, 4'b0001, 8'd0, 1'b0));
    step("rr4a", 4'b1111, mk(4'b0001, 4'b0001, 8'd1, 1'b0));
    step("rr4r", 4'b0000, mk(4'b0000, 4'b0010, 8'd0, 1'b0));

`ifdef ARB_TIMEOUT_EN
    // Constant request from bit 0: scan wraps past token 0010, preempt after 8 cycles
    for (int k = 1; k <= 8; k++) step("to_hold", 4'b0001, mk(4'b0001, 4'b0010, 8'(k), 1'b0));
    step("to_preempt", 4'b0001, mk(4'b0000, 4'b0010, 8'd0, 1'b1));
    step("to_regrant", 4'b0001, mk(4'b0001, 4'b0010, 8'd1, 1'b0));
    step("to_rel", 4'b0000, mk(4'b0000, 4'b0010, 8'd0, 1'b0));
`else
    // Owner holds for 20 cycles while non-owner bits toggle underneath
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] r;
      r = (k > 1 && (k % 2) == 1) ? 4'b1111 : 4'b0001;
      step("hold", r, mk(4'b0001, 4'b0010, 8'(k), 1'b0));
    end
    step("hold_rel", 4'b0000, mk(4'b0000, 4'b0010, 8'd0, 1'b0));
`endif

    // Asynchronous reset in the middle of a grant
    step("pre_async", 4'b0010, mk(4'b0010, 4'b0010, 8'd1, 1'b0));
    #2;
    reset = 1'b0;
    sb.push_back(mk(4'b0000, 4'b0001, 8'd0, 1'b0));
    #1;
    compare("async");
    bus.req = 4'b0011;
    @(negedge clk) reset = 1'b1;
    step("post_async", 4'b0011, mk(4'b0001, 4'b0001, 8'd1, 1'b0));
    step("post_rel", 4'b0000, mk(4'b0000, 4'b0010, 8'd0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ring_arbiter.md
Name: ring_arbiter

Overview:
- Round-robin arbiter that shares one resource between N requesters.
- Uses a one-hot rotating ring token, the same structure as the team's ring counter.
- Issues a one-hot registered grant and holds it while the owner keeps its request asserted.
- Bounds the hold time and rotates priority past each owner after release, so every requester gets fair access.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership (1..255); used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  N  request per requester, level-sensitive, held until served.
- grant  output  N  one-hot grant, registered; all-zero when idle.
- busy  output  1  high while any grant is active; equals OR of grant.
- token  output  N  one-hot ring pointer; the highest-priority requester for the next arbitration.
- hold_cnt  output  8  cycles the current owner has held the grant; 0 when idle.
- preempt  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (reset low, asynchronous):
  - token = 1 (bit 0).
  - grant = 0, busy = 0, hold_cnt = 0, preempt = 0, state = IDLE.
- Reset mid-grant: grant drops immediately, without waiting for a clock edge. After release, the first arbitration starts from bit 0.
- State machine has two states, IDLE and GRANT.
- IDLE, req == 0: stay in IDLE; token is unchanged.
- IDLE, req != 0: at the edge, grant <= sel, hold_cnt <= 1, state <= GRANT.
  - sel = first set req bit, scanning from the token position upward with wrap (index N-1 wraps to 0).
  - Latency: grant is asserted 1 cycle after req is sampled.
- GRANT: let owner be the set grant bit. At each edge:
  - If req[owner] == 0: release.
  - Else, if timeout is enabled and hold_cnt == MAX_HOLD: release and pulse preempt.
  - Else: hold_cnt <= hold_cnt + 1, saturating at 255.
- Release:
  - grant <= 0, hold_cnt <= 0, state <= IDLE.
  - token <= grant rotated left by 1 with wrap (owner N-1 goes to bit 0).
  - Exactly one IDLE cycle is inserted between consecutive grants, including when the same requester re-requests.
- Changes to non-owner req bits during GRANT are ignored and cause no glitches.
- Only the owner's req bit is examined during GRANT.
- grant is never multi-hot. token is always exactly one-hot.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The owner is preempted after MAX_HOLD cycles of grant.
  - preempt pulses for 1 cycle, coincident with grant falling.
  - The token rotates past the preempted owner.
  - A preempted requester that still holds req competes normally in later arbitrations.
- Undefined:
  - No timeout; the owner holds the grant until its req drops.
  - preempt is tied to 0.
  - hold_cnt still counts, saturating at 255.

Test Plan (N=4, MAX_HOLD=8):
- Reset then idle: reset low, req=0 -> grant=0000, token=0001, busy=0, hold_cnt=0; stays so for 10 cycles.
- Single requester: req=0100 held 3 cycles, then dropped.
  - Required: grant=0100 starting 1 cycle after req, for 3 cycles.
  - Then grant=0000 and token=1000.
- Round-robin fairness: req=1111, each owner drops req 2 cycles after its grant and re-raises it next cycle.
  - Grant order: 0001, 0010, 0100, 1000, 0001.
  - One idle cycle between grants; token wraps 1000 -> 0001.
- Timeout (ARB_TIMEOUT_EN): req=0001 held constantly.
  - grant=0001 for exactly 8 cycles, then preempt=1 for 1 cycle.
  - 1 idle cycle, then re-grant 0001; hold_cnt runs 1..8.
- No timeout (macro undefined): req=0001 held for 20 cycles.
  - grant stays 0001 for 20 cycles; preempt is never 1; hold_cnt reaches 20.
- Async reset mid-grant: grant=0010, then reset low between clock edges.
  - grant=0000 immediately, token=0001.
  - After reset releases with req=0011, the next grant is 0001.
